// File: rtl/ahb_mem_bridge.sv
// ahb_mem_bridge: runs single-word core requests as AHB-Lite SINGLE transfers.
// Handles one transfer at a time, including bus wait states, ERROR responses and misaligned requests.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   core_htrans     core request; 2'b10 means a request is present
//   core_hwrite     core request direction
//   core_addr       core byte address
//   core_wdata      core write data
//   req_ready       bridge idle; a request is accepted on this edge
//   rsp_valid       one-cycle completion pulse to the core
//   rsp_err         qualifies rsp_valid: bus ERROR or misaligned address
//   rsp_rdata       read data returned to the core
//   H*              AHB-Lite master signals
//
// Optional feature: define AHB_BRIDGE_RSP_REG_EN to register the response.
// This adds one cycle of latency and holds rsp_rdata between completions.
module ahb_mem_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        core_htrans,
    input  logic              core_hwrite,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ERR,
        S_MIS
    } state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [1:0]        htrans_q, htrans_d;
    logic              hwrite_q, hwrite_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cpl_vld;
    logic              cpl_err;
    logic              idle_ok;

    assign HADDR  = haddr_q;
    assign HTRANS = htrans_q;
    assign HWRITE = hwrite_q;
    assign HWDATA = hwdata_q;
    assign HSIZE  = 3'b010;
    assign HBURST = 3'b000;
    assign HPROT  = 4'b0011;

    assign req_ready = idle_ok;

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        hwdata_d = hwdata_q;
        wdata_d  = wdata_q;
        cpl_vld  = 1'b0;
        cpl_err  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (idle_ok && core_htrans == TR_NONSEQ) begin
                    if (core_addr[1:0] == 2'b00) begin
                        haddr_d  = core_addr;
                        hwrite_d = core_hwrite;
                        htrans_d = TR_NONSEQ;
                        wdata_d  = core_wdata;
                        state_d  = S_ADDR;
                    end else begin
                        state_d = S_MIS;
                    end
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    htrans_d = TR_IDLE;
                    if (hwrite_q) begin
                        hwdata_d = wdata_q;
                    end
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                // HRESP with HREADY high is illegal as a first
                // ERROR cycle; report it as an error anyway.
                if (HREADY) begin
                    cpl_vld = 1'b1;
                    cpl_err = HRESP;
                    state_d = S_IDLE;
                end else if (HRESP) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                if (HREADY) begin
                    cpl_vld = 1'b1;
                    cpl_err = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_MIS: begin
                cpl_vld = 1'b1;
                cpl_err = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            haddr_q  <= '0;
            htrans_q <= TR_IDLE;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
            wdata_q  <= wdata_d;
        end
    end

`ifdef AHB_BRIDGE_RSP_REG_EN
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= cpl_vld;
            rsp_err_q   <= cpl_vld & cpl_err;
            if (cpl_vld) begin
                rsp_rdata_q <= HRDATA;
            end
        end
    end

    // A new request is taken only after the core has seen the
    // registered completion.
    assign idle_ok   = (state_q == S_IDLE) && !rsp_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
`else
    assign idle_ok   = (state_q == S_IDLE);
    assign rsp_valid = cpl_vld;
    assign rsp_err   = cpl_err;
    // Read data is a pass-through; it is forced to zero only while reset is asserted.
    assign rsp_rdata = rst ? HRDATA : '0;
`endif

endmodule
